// File: rtl/frog_game_fsm_if.sv
// Game-flow signal bundle: collision/goal verdicts, buttons and frame tick in; play-state, counters and strobes out.
// master drives the verdicts and buttons, slave is the game-flow controller.
interface frog_game_fsm_if;
    logic       frame_tick;
    logic [3:0] dpad_input;
    logic       collision;
    logic       reached_end;
    logic [2:0] game_state;
    logic       freeze;
    logic       frog_reset;
    logic [2:0] lives;
    logic [7:0] score;
    logic       win_pulse;
    logic       lose_pulse;

    modport master (
        output frame_tick, dpad_input, collision, reached_end,
        input  game_state, freeze, frog_reset, lives, score, win_pulse, lose_pulse
    );

    modport slave (
        input  frame_tick, dpad_input, collision, reached_end,
        output game_state, freeze, frog_reset, lives, score, win_pulse, lose_pulse
    );
endinterface

// File: rtl/frog_game_fsm.sv
// Frogger game-flow FSM: all outputs registered, one edge after the sampled event; buttons add 3 edges.
// No backpressure: inputs are levels or single-cycle pulses consumed every cycle.
module frog_game_fsm #(
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 90
) (
    input  logic           clk,
    input  logic           reset,
    frog_game_fsm_if.slave gio
);
    typedef enum logic [2:0] {
        ST_TITLE = 3'd0,
        ST_PLAY  = 3'd1,
        ST_DYING = 3'd2,
        ST_HOME  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [6:0] DEATH_LAST = 7'(DEATH_FRAMES - 1);
    localparam logic [6:0] WIN_LAST   = 7'(WIN_FRAMES - 1);

    state_e     state_q;
    logic [3:0] btn_meta_q, btn_sync_q;
    logic       any_q, start_q;
    logic [6:0] cnt_q;
    logic [2:0] lives_q;
    logic [7:0] score_q;
    logic       freeze_q, frog_reset_q, win_q, lose_q;
    logic       any_btn, start_d;

    assign any_btn = |btn_sync_q;
    assign start_d = any_btn & ~any_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            any_q      <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            btn_meta_q <= gio.dpad_input;
            btn_sync_q <= btn_meta_q;
            any_q      <= any_btn;
            start_q    <= start_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_TITLE;
            cnt_q        <= '0;
            lives_q      <= '0;
            score_q      <= '0;
            freeze_q     <= 1'b1;
            frog_reset_q <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            frog_reset_q <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            case (state_q)
                ST_TITLE: if (start_q) begin
                    state_q      <= ST_PLAY;
                    cnt_q        <= '0;
                    lives_q      <= 3'(LIVES);
                    score_q      <= '0;
                    freeze_q     <= 1'b0;
                    frog_reset_q <= 1'b1;
                end
                ST_PLAY: begin
                    // A death outranks a simultaneous goal arrival.
                    if (gio.collision) begin
                        state_q  <= ST_DYING;
                        cnt_q    <= '0;
                        lives_q  <= lives_q - 3'd1;
                        freeze_q <= 1'b1;
                        lose_q   <= 1'b1;
                    end else if (gio.reached_end) begin
                        state_q  <= ST_HOME;
                        cnt_q    <= '0;
                        score_q  <= (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        freeze_q <= 1'b1;
                        win_q    <= 1'b1;
                    end
                end
                ST_DYING: if (gio.frame_tick) begin
                    if (cnt_q == DEATH_LAST) begin
                        cnt_q <= '0;
                        if (lives_q != 3'd0) begin
                            state_q      <= ST_PLAY;
                            freeze_q     <= 1'b0;
                            frog_reset_q <= 1'b1;
                        end else begin
                            state_q <= ST_OVER;
                        end
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                ST_HOME: if (gio.frame_tick) begin
                    if (cnt_q == WIN_LAST) begin
                        state_q      <= ST_PLAY;
                        cnt_q        <= '0;
                        freeze_q     <= 1'b0;
                        frog_reset_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                ST_OVER: if (start_q) begin
                    state_q <= ST_TITLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q  <= ST_TITLE;
                    cnt_q    <= '0;
                    freeze_q <= 1'b1;
                end
            endcase
        end
    end

    assign gio.game_state = state_q;
    assign gio.freeze     = freeze_q;
    assign gio.frog_reset = frog_reset_q;
    assign gio.lives      = lives_q;
    assign gio.score      = score_q;
    assign gio.win_pulse  = win_q;
    assign gio.lose_pulse = lose_q;
endmodule

// File: tb/tb_frog_game_fsm.sv
// Randomized bench for frog_game_fsm against a tick-countdown / button-history reference model.
module tb_frog_game_fsm;
    localparam int P_LIVES = 3;
    localparam int P_DEATH = 60;
    localparam int P_WIN   = 90;
    localparam logic [17:0] RST_OUTS = {3'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    frog_game_fsm_if gio();

    frog_game_fsm #(.LIVES(P_LIVES), .DEATH_FRAMES(P_DEATH), .WIN_FRAMES(P_WIN)) dut (
        .clk   (clk),
        .reset (reset),
        .gio   (gio)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: states as plain numbers, dwell as remaining ticks, buttons as a history of any-pressed.
    int m_state, m_lives, m_score, m_left;
    bit m_frz, m_fr, m_win, m_lose;
    bit hist[5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_score = 0; m_left = 0;
        m_frz = 1'b1; m_fr = 1'b0; m_win = 1'b0; m_lose = 1'b0;
        for (int i = 0; i < 5; i++) hist[i] = 1'b0;
    endtask

    task automatic model_step();
        bit start;
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = |gio.dpad_input;
        start = hist[3] && !hist[4];
        m_fr = 1'b0; m_win = 1'b0; m_lose = 1'b0;
        case (m_state)
            0: if (start) begin m_state = 1; m_lives = P_LIVES; m_score = 0; m_fr = 1'b1; end
            1: if (gio.collision) begin
                   m_state = 2; m_lives = m_lives - 1; m_lose = 1'b1; m_left = P_DEATH;
               end else if (gio.reached_end) begin
                   m_state = 3; if (m_score < 255) m_score = m_score + 1; m_win = 1'b1; m_left = P_WIN;
               end
            2: if (gio.frame_tick) begin
                   m_left = m_left - 1;
                   if (m_left == 0) begin
                       if (m_lives > 0) begin m_state = 1; m_fr = 1'b1; end
                       else m_state = 4;
                   end
               end
            3: if (gio.frame_tick) begin
                   m_left = m_left - 1;
                   if (m_left == 0) begin m_state = 1; m_fr = 1'b1; end
               end
            4: if (start) m_state = 0;
            default: m_state = 0;
        endcase
        m_frz = (m_state != 1);
    endtask

    function automatic logic [17:0] model_outs();
        return {3'(m_state), m_frz, m_fr, 3'(m_lives), 8'(m_score), m_win, m_lose};
    endfunction

    function automatic logic [17:0] dut_outs();
        return {gio.game_state, gio.freeze, gio.frog_reset, gio.lives, gio.score,
                gio.win_pulse, gio.lose_pulse};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("outs", dut_outs(), model_outs());
    endtask

    task automatic drive(input logic tick, input logic coll, input logic reach, input logic [3:0] dpad);
        gio.frame_tick = tick; gio.collision = coll; gio.reached_end = reach; gio.dpad_input = dpad;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_outs", dut_outs(), RST_OUTS);
        reset = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget, input logic [3:0] dpad, input string tag);
        int n = 0;
        gio.dpad_input = dpad;
        while (m_state != target && n < budget) begin
            gio.frame_tick = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        chk(tag, gio.game_state, target);
    endtask

    // Dwell measured in ticks presented while the DUT sits in the given state.
    task automatic count_dwell(input logic [2:0] st, input int exp_ticks, input string tag);
        int ticks = 0;
        int n = 0;
        while (gio.game_state == st && n < 1000) begin
            gio.frame_tick = 1'($urandom_range(0, 1));
            if (gio.frame_tick) ticks++;
            cycle();
            n++;
        end
        gio.frame_tick = 1'b0;
        chk({tag, "_ticks"}, ticks, exp_ticks);
    endtask

    initial begin
        int first, fr_cnt, win_cnt, n;
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        do_reset();

        // Start: hold up for 10 cycles.
        first = -1; fr_cnt = 0;
        gio.dpad_input = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            cycle();
            fr_cnt += int'(gio.frog_reset);
            if (first < 0 && gio.game_state == 3'd1) first = i;
        end
        gio.dpad_input = 4'd0;
        chk("start_latency", first, 3);
        chk("start_fr_count", fr_cnt, 1);
        chk("start_lives", gio.lives, 3);
        chk("start_freeze", gio.freeze, 0);

        // Death and respawn.
        gio.collision = 1'b1;
        cycle();
        gio.collision = 1'b0;
        chk("die_state", gio.game_state, 2);
        chk("die_lives", gio.lives, 2);
        chk("die_lose", gio.lose_pulse, 1);
        chk("die_freeze", gio.freeze, 1);
        count_dwell(3'd2, P_DEATH, "death");
        chk("respawn_state", gio.game_state, 1);
        chk("respawn_fr", gio.frog_reset, 1);

        // Collision and goal together: death wins.
        gio.collision = 1'b1; gio.reached_end = 1'b1;
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        chk("both_state", gio.game_state, 2);
        chk("both_score", gio.score, 0);
        chk("both_win", gio.win_pulse, 0);
        run_until(1, 1000, 4'd0, "both_back");

        // Clean crossing.
        gio.reached_end = 1'b1;
        cycle();
        gio.reached_end = 1'b0;
        chk("home_state", gio.game_state, 3);
        chk("home_score", gio.score, 1);
        chk("home_win", gio.win_pulse, 1);
        count_dwell(3'd3, P_WIN, "home");
        chk("home_back_fr", gio.frog_reset, 1);

        // Last life lost: game over, no respawn, counters held for display.
        gio.collision = 1'b1;
        cycle();
        gio.collision = 1'b0;
        chk("last_lives", gio.lives, 0);
        count_dwell(3'd2, P_DEATH, "last");
        chk("over_state", gio.game_state, 4);
        chk("over_fr", gio.frog_reset, 0);
        run_until(0, 20, 4'b0001, "over_to_title");
        chk("title_score_held", gio.score, 1);
        repeat (4) cycle();

        // Random play.
        for (int i = 0; i < 6000; i++) begin
            gio.frame_tick  = ($urandom_range(0, 2) == 0);
            gio.collision   = ($urandom_range(0, 23) == 0);
            gio.reached_end = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 19) == 0)
                gio.dpad_input = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'd0;
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset in DYING alongside a frame tick.
        do_reset();
        run_until(1, 20, 4'b1000, "mid_play");
        gio.collision = 1'b1;
        cycle();
        gio.collision = 1'b0;
        repeat (5) begin gio.frame_tick = 1'b1; cycle(); end
        chk("mid_dying", gio.game_state, 2);
        gio.frame_tick = 1'b1;
        #2 reset = 1'b1;
        #1 chk("async_rst", dut_outs(), RST_OUTS);
        model_reset();
        @(negedge clk);
        gio.frame_tick = 1'b0;
        @(negedge clk);
        chk("rst_hold", dut_outs(), RST_OUTS);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            gio.frame_tick = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("idle_title", dut_outs(), RST_OUTS);

        // Score saturation.
        run_until(1, 20, 4'b0010, "sat_play");
        win_cnt = 0; n = 0;
        gio.reached_end = 1'b1; gio.frame_tick = 1'b1;
        while (win_cnt < 258 && n < 30000) begin
            cycle();
            win_cnt += int'(gio.win_pulse);
            n++;
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        chk("sat_wins", win_cnt, 258);
        chk("sat_score", gio.score, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frog_game_fsm.md
# frog_game_fsm

Game-flow controller for the frogger datapath. It consumes the per-cycle `collision` and `reached_end` verdicts and the raw button levels. It produces the play-state, a one-cycle frog-respawn strobe, lives and score counters, a movement freeze, and one-cycle win/lose strobes for the audio block. It sits between the collision logic and the frog, audio and HUD consumers, and runs in the 25.1 MHz pixel domain.

## Interface
Parameters:
- `LIVES`, 3: lives granted at game start, 1..7.
- `DEATH_FRAMES`, 60: frame ticks spent in DYING.
- `WIN_FRAMES`, 90: frame ticks spent in HOME.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: pixel clock, `osc_25_1M`.
- `reset` in 1: asynchronous, active-high; returns the whole block to TITLE.
- `frame_tick` in 1: one-cycle pulse per video frame, at the VSYNC start.
- `dpad_input` in 4: raw buttons {right, up, down, left}, active-high, asynchronous to `clk`.
- `collision` in 1: frog hit a car, water or screen edge; level.
- `reached_end` in 1: frog is in the goal row; level.
- `game_state` out 3: 0 TITLE, 1 PLAY, 2 DYING, 3 HOME, 4 GAMEOVER.
- `freeze` out 1: high in every state except PLAY; the frog ignores dpad input while high.
- `frog_reset` out 1: one-cycle pulse; the frog returns to its initial x/y.
- `lives` out 3: remaining lives.
- `score` out 8: completed crossings, saturating at 255.
- `win_pulse` out 1: one-cycle pulse to the audio win input.
- `lose_pulse` out 1: one-cycle pulse to the audio lose input.

## Operation
- **Button synchronizer:** `dpad_input` passes through a 2-flop synchronizer per bit.
  - `any_btn` = OR of the synchronized bits.
  - `start` = rising edge of `any_btn`, taken against a third register.
  - `start` is one cycle wide and needs a release before it can fire again.
- **Frame counter:** 7 bits, cleared on every state entry. It increments on `frame_tick` only while in DYING or HOME.
- **TITLE:**
  - On `start`, go to PLAY.
  - In the same edge: `lives` ← LIVES, `score` ← 0, `frog_reset` = 1.
- **PLAY:**
  - `collision` = 1: go to DYING. In the same edge, `lives` ← `lives` − 1 and `lose_pulse` = 1.
  - `collision` = 0 and `reached_end` = 1: go to HOME. In the same edge, `score` ← `score` + 1 (held at 255) and `win_pulse` = 1.
  - Both high in the same cycle: `collision` wins, and the score is unchanged.
- **DYING:**
  - When the counter reaches DEATH_FRAMES (the edge that counts the DEATH_FRAMES-th tick) and `lives` ≠ 0: go to PLAY with `frog_reset` = 1.
  - When the counter reaches DEATH_FRAMES and `lives` = 0: go to GAMEOVER with no `frog_reset`.
  - `collision`, `reached_end` and `start` are ignored.
- **HOME:** when the counter reaches WIN_FRAMES, go to PLAY with `frog_reset` = 1. Inputs are ignored.
- **GAMEOVER:**
  - On `start`, go to TITLE.
  - `lives` and `score` hold their values for display until the next game starts.
- **Illegal `game_state` encodings (5–7):** go to TITLE on the next edge.
- **Lives:** decremented only on a PLAY→DYING transition, so it never wraps. With `lives` = 1, a hit leads to `lives` = 0 and then GAMEOVER.
- **Reset values:**
  - `game_state` = TITLE, `freeze` = 1.
  - `lives` = 0, `score` = 0.
  - `frog_reset`, `win_pulse`, `lose_pulse` = 0.
  - Counter and synchronizer flops = 0.
- **Reset mid-operation:** asserting `reset` at any point, including in DYING or HOME, clears everything immediately. No pending pulse is emitted after `reset` is released.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Event at cycle N (`collision` or `reached_end` sampled high in PLAY): at edge N+1, `game_state`, `lives`/`score` and the strobe all update together.
- Strobes are exactly one cycle wide.
- `freeze` is derived from the registered state and therefore rises in the same cycle as `game_state` leaves PLAY.
- Button latency: a `dpad_input` rise seen at edge k produces `start` at edge k+2. The state changes at edge k+3.
- `frame_tick` handling:
  - A tick in the same cycle as a state entry is not counted.
  - DYING and HOME dwell times therefore span exactly DEATH_FRAMES or WIN_FRAMES tick edges after entry.
- `collision` held high across PLAY re-entry: after `frog_reset`, the first PLAY cycle samples `collision`. The frog datapath clears it within 1 cycle, and a still-high level causes another death.

## Test plan
- **Start game:** reset, then press the up button for 10 cycles.
  - Expect `game_state` = 1 at edge 3 after the press, `lives` = 3, `score` = 0.
  - Expect a single `frog_reset` pulse and `freeze` = 0.
- **Death and respawn:** in PLAY, pulse `collision` for 1 cycle.
  - Next edge: `game_state` = 2, `lives` = 2, `lose_pulse` for 1 cycle, `freeze` = 1.
  - After 60 `frame_tick`s: `game_state` = 1 and `frog_reset` for 1 cycle.
- **Game over:** cause 3 deaths with DEATH_FRAMES = 2.
  - After the third death, `game_state` = 4 with `lives` = 0 and no `frog_reset`.
  - A button press then returns to `game_state` = 0.
- **Crossing:** in PLAY, raise `reached_end` and `collision` in the same cycle.
  - Expect DYING, `score` unchanged, and no `win_pulse`.
  - Repeat with `reached_end` alone: expect HOME, `score` + 1, `win_pulse`, and return to PLAY after 90 ticks.
- **Score saturation:** force 256 crossings with WIN_FRAMES = 1; `score` stays at 255.
- **Reset mid-operation:** assert `reset` in DYING, in the same cycle as a `frame_tick`.
  - Outputs take their reset values immediately, with no strobes.
  - After release, the block idles in TITLE until `start`.
